// File: rtl/tpu_pkg.sv
// Shared types and constants for the systolic array datapath and its
// downstream stages (signed Q8.8 partial sums).
package tpu_pkg;

  localparam int DATA_WIDTH = 16;
  localparam int NUM_LANES  = 2;

  typedef logic signed [DATA_WIDTH-1:0] psum_t;
  typedef psum_t [NUM_LANES-1:0] psum_vec_t;

  localparam psum_t PSUM_MAX = psum_t'(16'h7FFF);
  localparam psum_t PSUM_MIN = psum_t'(16'h8000);

  typedef enum logic {
    IDLE  = 1'b0,
    ACCUM = 1'b1
  } acc_state_e;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with registered storage; pop is serviced before push so a
// simultaneous push/pop on a full FIFO loses nothing.
module sync_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4,
  localparam int AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             full,
  output logic             empty
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             do_push;
  logic             do_pop;

  // Extra pointer bit distinguishes full from empty when the indices match.
  assign empty    = (wr_ptr == rd_ptr);
  assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_pop   = pop && !empty;
  assign do_push  = push && (!full || do_pop);
  assign pop_data = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr[AW-1:0]] <= push_data;
        wr_ptr              <= wr_ptr + 1'b1;
      end
      if (do_pop) rd_ptr <= rd_ptr + 1'b1;
    end
  end

endmodule

// File: rtl/psum_deskew_acc.sv
// Deskews the bottom-row psums of the PE array into aligned row vectors,
// accumulates them over K-tiles in a row bank and queues finished rows.
module psum_deskew_acc
  import tpu_pkg::*;
#(
  parameter int N          = 2,
  parameter int ROWS       = 4,
  parameter int FIFO_DEPTH = 4,
  parameter int DATA_WIDTH = tpu_pkg::DATA_WIDTH,
  localparam int RW        = (ROWS > 1) ? $clog2(ROWS) : 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    cfg_start,
  input  logic [7:0]              cfg_passes,
  input  logic [N*DATA_WIDTH-1:0] col_psum_in,
  input  logic [N-1:0]            col_valid_in,
  output logic [N*DATA_WIDTH-1:0] out_vec,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic                    busy,
  output logic                    err_overflow,
  output logic                    err_skew,
  output logic                    sat,
  output acc_state_e              dbg_state,
  output logic [RW-1:0]           dbg_row_ptr
);

  localparam int W = DATA_WIDTH;
  typedef logic [N-1:0][W-1:0] vec_t;

  // Returns {clamped, sum}; clamps to the most positive/negative lane value.
  function automatic logic [W:0] sat_add(input logic [W-1:0] a, input logic [W-1:0] b);
    logic [W:0] s;
    s = {a[W-1], a} + {b[W-1], b};
    if (s[W] != s[W-1]) return {1'b1, s[W], {(W-1){~s[W]}}};
    return {1'b0, s[W-1:0]};
  endfunction

  acc_state_e  state, state_d;
  vec_t        in_vec, lane_d, align_d, acc_cur, result;
  logic [N-1:0] lane_v, align_v;
  vec_t        acc_q [ROWS];
  logic [RW-1:0] row_ptr;
  logic [7:0]  pass_cnt, passes;
  logic        vec_ok, vec_mixed, do_proc, last_pass, row_wrap, start_ok;
  logic        clamp_any, push, pop, fifo_full, fifo_empty;

  assign in_vec = col_psum_in;

  // Lane j waits N-1-j cycles so every lane of a row meets the align stage together.
  for (genvar j = 0; j < N; j++) begin : g_lane
    localparam int D = N - 1 - j;
    if (D == 0) begin : g_direct
      assign lane_d[j] = in_vec[j];
      assign lane_v[j] = col_valid_in[j];
    end else begin : g_dly
      logic [W-1:0] d_q [D];
      logic [D-1:0] v_q;
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          v_q <= '0;
          for (int k = 0; k < D; k++) d_q[k] <= '0;
        end else begin
          d_q[0] <= in_vec[j];
          v_q[0] <= col_valid_in[j];
          for (int k = 1; k < D; k++) begin
            d_q[k] <= d_q[k-1];
            v_q[k] <= v_q[k-1];
          end
        end
      end
      assign lane_d[j] = d_q[D-1];
      assign lane_v[j] = v_q[D-1];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      align_d <= '0;
      align_v <= '0;
    end else begin
      align_d <= lane_d;
      align_v <= lane_v;
    end
  end

  assign vec_ok    = &align_v;
  assign vec_mixed = (|align_v) && !vec_ok;
  assign do_proc   = (state == ACCUM) && vec_ok;
  assign last_pass = (pass_cnt == passes - 8'd1);
  assign row_wrap  = (row_ptr == RW'(ROWS - 1));
  assign start_ok  = (state == IDLE) && cfg_start;
  assign push      = do_proc && last_pass;
  assign pop       = out_valid && out_ready;

  always_comb begin
    logic [W:0] t;
    acc_cur   = acc_q[row_ptr];
    result    = align_d;
    clamp_any = 1'b0;
    t         = '0;
    if (pass_cnt != 8'd0) begin
      for (int j = 0; j < N; j++) begin
        t         = sat_add(acc_cur[j], align_d[j]);
        result[j] = t[W-1:0];
        clamp_any = clamp_any | t[W];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_d;
  end

  always_comb begin
    state_d = state;
    case (state)
      IDLE:    if (cfg_start) state_d = ACCUM;
      ACCUM:   if (do_proc && row_wrap && last_pass) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      passes       <= 8'd1;
      row_ptr      <= '0;
      pass_cnt     <= '0;
      err_overflow <= 1'b0;
      err_skew     <= 1'b0;
      sat          <= 1'b0;
      for (int r = 0; r < ROWS; r++) acc_q[r] <= '0;
    end else if (start_ok) begin
      passes       <= (cfg_passes == 8'd0) ? 8'd1 : cfg_passes;
      row_ptr      <= '0;
      pass_cnt     <= '0;
      err_overflow <= 1'b0;
      err_skew     <= 1'b0;
      sat          <= 1'b0;
    end else if (state == ACCUM) begin
      if (vec_mixed) err_skew <= 1'b1;
      if (do_proc) begin
        acc_q[row_ptr] <= result;
        if (clamp_any) sat <= 1'b1;
        if (push && fifo_full && !pop) err_overflow <= 1'b1;
        row_ptr <= row_wrap ? '0 : row_ptr + RW'(1);
        if (row_wrap) pass_cnt <= pass_cnt + 8'd1;
      end
    end
  end

  sync_fifo #(
    .WIDTH (N * W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data (result),
    .pop       (pop),
    .pop_data  (out_vec),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  assign out_valid   = !fifo_empty;
  assign busy        = (state != IDLE);
  assign dbg_state   = state;
  assign dbg_row_ptr = row_ptr;

endmodule

// File: tb/tb_psum_deskew_acc.sv
// Directed bench for psum_deskew_acc: N=2, ROWS=4, FIFO_DEPTH=2, skewed column
// feed, expected-row queue checked at every accepted output.
module tb_psum_deskew_acc;
  import tpu_pkg::*;

  localparam int N = 2;
  localparam int ROWS = 4;
  localparam int FIFO_DEPTH = 2;
  localparam int W = 16;

  logic              clk = 1'b0;
  logic              rst;
  logic              cfg_start;
  logic [7:0]        cfg_passes;
  logic [N*W-1:0]    col_psum_in;
  logic [N-1:0]      col_valid_in;
  logic [N*W-1:0]    out_vec;
  logic              out_valid;
  logic              out_ready;
  logic              busy;
  logic              err_overflow;
  logic              err_skew;
  logic              sat;
  acc_state_e        dbg_state;
  logic [1:0]        dbg_row_ptr;

  int          n_vec = 0;
  int          n_bad = 0;
  logic [31:0] exp_q[$];
  logic [W-1:0] row_l0 [8];
  logic [W-1:0] row_l1 [8];
  bit          lat_chk = 1'b0;

  psum_deskew_acc #(
    .N (N), .ROWS (ROWS), .FIFO_DEPTH (FIFO_DEPTH), .DATA_WIDTH (W)
  ) dut (
    .clk (clk), .rst (rst), .cfg_start (cfg_start), .cfg_passes (cfg_passes),
    .col_psum_in (col_psum_in), .col_valid_in (col_valid_in),
    .out_vec (out_vec), .out_valid (out_valid), .out_ready (out_ready),
    .busy (busy), .err_overflow (err_overflow), .err_skew (err_skew), .sat (sat),
    .dbg_state (dbg_state), .dbg_row_ptr (dbg_row_ptr)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic expect_row(input psum_t l0, input psum_t l1);
    psum_vec_t v;
    v[0] = l0;
    v[1] = l1;
    exp_q.push_back(v);
  endtask

  task automatic set_row(input int i, input logic [W-1:0] l0, input logic [W-1:0] l1);
    row_l0[i] = l0;
    row_l1[i] = l1;
  endtask

  task automatic drive(input logic v0, input logic [W-1:0] d0, input logic v1, input logic [W-1:0] d1);
    col_valid_in = {v1, v0};
    col_psum_in  = {d1, d0};
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic start_tile(input logic [7:0] p);
    @(negedge clk);
    cfg_passes = p;
    cfg_start  = 1'b1;
    @(negedge clk);
    cfg_start  = 1'b0;
  endtask

  // Column 0 carries row base+k while column 1 carries row base+k-1.
  task automatic feed(input int base, input int n, input int ready_at);
    for (int k = 0; k <= n; k++) begin
      @(negedge clk);
      if (k == ready_at) out_ready = 1'b1;
      if (lat_chk && k == 2) check("latency_pre", 32'(out_valid), 32'd0);
      if (lat_chk && k == 3) check("latency_post", 32'(out_valid), 32'd1);
      drive(k < n, (k < n) ? row_l0[base+k] : '0,
            k >= 1, (k >= 1) ? row_l1[base+k-1] : '0);
    end
    @(negedge clk);
    drive(1'b0, '0, 1'b0, '0);
  endtask

  // Every accepted head must match the oldest expected row.
  initial begin
    forever begin
      @(negedge clk);
      #2;
      if (rst !== 1'b1 && out_valid && out_ready) begin
        n_vec++;
        assert (exp_q.size() != 0) else begin
          n_bad++;
          $error("FAIL out_unexpected: observed %h expected no output", out_vec);
        end
        if (exp_q.size() != 0) check("out_vec", out_vec, exp_q.pop_front());
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "bench timeout");
  end

  initial begin
    rst = 1'b1;
    cfg_start = 1'b0;
    cfg_passes = 8'd0;
    col_psum_in = '0;
    col_valid_in = '0;
    out_ready = 1'b0;
    wait_cyc(2);
    rst = 1'b0;
    @(negedge clk);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_out_vec", out_vec, 32'd0);
    check("rst_flags", {29'd0, err_overflow, err_skew, sat}, 32'd0);
    check("rst_state", 32'(dbg_state), 32'(IDLE));

    // Single pass
    out_ready = 1'b1;
    set_row(0, 16'h0100, 16'h0200); set_row(1, 16'h0300, 16'h0400);
    set_row(2, 16'h0500, 16'h0600); set_row(3, 16'h0700, 16'h0800);
    expect_row(16'h0100, 16'h0200); expect_row(16'h0300, 16'h0400);
    expect_row(16'h0500, 16'h0600); expect_row(16'h0700, 16'h0800);
    start_tile(8'd1);
    check("p1_busy", 32'(busy), 32'd1);
    lat_chk = 1'b1;
    feed(0, 4, -1);
    lat_chk = 1'b0;
    check("p1_busy_before_last", 32'(busy), 32'd1);
    @(negedge clk);
    check("p1_busy_fall", 32'(busy), 32'd0);
    check("p1_last_valid", 32'(out_valid), 32'd1);
    wait_cyc(3);
    check("p1_drained", 32'(exp_q.size()), 32'd0);
    check("p1_flags", {29'd0, err_overflow, err_skew, sat}, 32'd0);

    // Two passes: rows fed twice, only doubled rows emerge
    for (int i = 0; i < 4; i++) set_row(i + 4, row_l0[i], row_l1[i]);
    expect_row(16'h0200, 16'h0400); expect_row(16'h0600, 16'h0800);
    expect_row(16'h0A00, 16'h0C00); expect_row(16'h0E00, 16'h1000);
    start_tile(8'd2);
    feed(0, 8, -1);
    wait_cyc(4);
    check("p2_busy", 32'(busy), 32'd0);
    check("p2_drained", 32'(exp_q.size()), 32'd0);
    check("p2_sat", 32'(sat), 32'd0);

    // Saturation in both directions, plus an exact -32768 that must not clamp
    set_row(0, 16'h7F00, 16'h8100); set_row(1, 16'h0100, 16'hFF00);
    set_row(2, 16'h4000, 16'hC000); set_row(3, 16'h3FFF, 16'h0001);
    for (int i = 0; i < 4; i++) set_row(i + 4, row_l0[i], row_l1[i]);
    expect_row(PSUM_MAX, PSUM_MIN);   expect_row(16'h0200, 16'hFE00);
    expect_row(PSUM_MAX, 16'h8000);   expect_row(16'h7FFE, 16'h0002);
    start_tile(8'd2);
    feed(0, 8, -1);
    wait_cyc(4);
    check("sat_flag", 32'(sat), 32'd1);
    check("sat_drained", 32'(exp_q.size()), 32'd0);

    // Skew error: lane1 valid one cycle late
    start_tile(8'd1);
    check("sat_cleared", 32'(sat), 32'd0);
    @(negedge clk); drive(1'b1, 16'h0A0A, 1'b0, '0);
    @(negedge clk); drive(1'b0, '0, 1'b0, '0);
    @(negedge clk); drive(1'b0, '0, 1'b1, 16'h0B0B);
    @(negedge clk); drive(1'b0, '0, 1'b0, '0);
    wait_cyc(2);
    check("skew_flag", 32'(err_skew), 32'd1);
    check("skew_row_ptr", 32'(dbg_row_ptr), 32'd0);
    check("skew_no_push", 32'(out_valid), 32'd0);
    check("skew_busy", 32'(busy), 32'd1);
    set_row(0, 16'h0010, 16'h0020); set_row(1, 16'h0030, 16'h0040);
    set_row(2, 16'h0050, 16'h0060); set_row(3, 16'h0070, 16'h0080);
    expect_row(16'h0010, 16'h0020); expect_row(16'h0030, 16'h0040);
    expect_row(16'h0050, 16'h0060); expect_row(16'h0070, 16'h0080);
    feed(0, 4, -1);
    wait_cyc(4);
    check("skew_done", 32'(busy), 32'd0);
    check("skew_drained", 32'(exp_q.size()), 32'd0);
    check("skew_sticky", 32'(err_skew), 32'd1);

    // Backpressure: depth-2 FIFO keeps rows 0,1 and drops rows 2,3
    out_ready = 1'b0;
    start_tile(8'd1);
    check("skew_cleared", 32'(err_skew), 32'd0);
    set_row(0, 16'h0A00, 16'h0B00); set_row(1, 16'h0C00, 16'h0D00);
    set_row(2, 16'h0E00, 16'h0F00); set_row(3, 16'h1000, 16'h1100);
    feed(0, 4, -1);
    @(negedge clk);
    check("bp_overflow", 32'(err_overflow), 32'd1);
    check("bp_valid", 32'(out_valid), 32'd1);
    check("bp_head", out_vec, 32'h0B00_0A00);
    check("bp_busy", 32'(busy), 32'd0);
    wait_cyc(3);
    check("bp_head_stable", out_vec, 32'h0B00_0A00);
    expect_row(16'h0A00, 16'h0B00); expect_row(16'h0C00, 16'h0D00);
    out_ready = 1'b1;
    wait_cyc(3);
    check("bp_empty", 32'(out_valid), 32'd0);
    check("bp_drained", 32'(exp_q.size()), 32'd0);

    // Full FIFO with push and pop together; cfg_passes=0 behaves as 1
    out_ready = 1'b0;
    start_tile(8'd0);
    check("ovf_cleared", 32'(err_overflow), 32'd0);
    set_row(0, 16'h0101, 16'h0202); set_row(1, 16'h0303, 16'h0404);
    set_row(2, 16'h0505, 16'h0606); set_row(3, 16'h0707, 16'h0808);
    expect_row(16'h0101, 16'h0202); expect_row(16'h0303, 16'h0404);
    expect_row(16'h0505, 16'h0606); expect_row(16'h0707, 16'h0808);
    feed(0, 4, 4);
    wait_cyc(4);
    check("pp_no_drop", 32'(err_overflow), 32'd0);
    check("pp_drained", 32'(exp_q.size()), 32'd0);
    check("pp_busy", 32'(busy), 32'd0);

    // cfg_start while accumulating is ignored
    out_ready = 1'b1;
    set_row(0, 16'h0001, 16'h0002); set_row(1, 16'h0003, 16'h0004);
    set_row(2, 16'h0005, 16'h0006); set_row(3, 16'h0007, 16'h0008);
    expect_row(16'h0001, 16'h0002); expect_row(16'h0003, 16'h0004);
    expect_row(16'h0005, 16'h0006); expect_row(16'h0007, 16'h0008);
    start_tile(8'd1);
    feed(0, 2, -1);
    wait_cyc(2);
    check("ign_row_ptr_pre", 32'(dbg_row_ptr), 32'd2);
    start_tile(8'd3);
    check("ign_busy", 32'(busy), 32'd1);
    check("ign_row_ptr", 32'(dbg_row_ptr), 32'd2);
    feed(2, 2, -1);
    wait_cyc(3);
    check("ign_done", 32'(busy), 32'd0);
    check("ign_drained", 32'(exp_q.size()), 32'd0);

    // Reset mid-tile with queued rows and a sticky flag set
    out_ready = 1'b0;
    start_tile(8'd1);
    feed(0, 2, -1);
    @(negedge clk); drive(1'b1, 16'h0100, 1'b0, '0);
    @(negedge clk); drive(1'b0, '0, 1'b0, '0);
    wait_cyc(2);
    check("mid_skew", 32'(err_skew), 32'd1);
    check("mid_valid", 32'(out_valid), 32'd1);
    @(negedge clk);
    #3 rst = 1'b1;
    #1;
    check("mr_out_valid", 32'(out_valid), 32'd0);
    check("mr_busy", 32'(busy), 32'd0);
    check("mr_out_vec", out_vec, 32'd0);
    check("mr_flags", {29'd0, err_overflow, err_skew, sat}, 32'd0);
    check("mr_state", 32'(dbg_state), 32'(IDLE));
    check("mr_row_ptr", 32'(dbg_row_ptr), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    out_ready = 1'b1;
    set_row(0, 16'h0100, 16'h0200); set_row(1, 16'h0300, 16'h0400);
    set_row(2, 16'h0500, 16'h0600); set_row(3, 16'h0700, 16'h0800);
    for (int i = 0; i < 4; i++) set_row(i + 4, row_l0[i], row_l1[i]);
    expect_row(16'h0200, 16'h0400); expect_row(16'h0600, 16'h0800);
    expect_row(16'h0A00, 16'h0C00); expect_row(16'h0E00, 16'h1000);
    start_tile(8'd2);
    feed(0, 8, -1);
    wait_cyc(4);
    check("post_rst_busy", 32'(busy), 32'd0);
    check("post_rst_drained", 32'(exp_q.size()), 32'd0);
    check("post_rst_flags", {29'd0, err_overflow, err_skew, sat}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
